// File: rtl/mem_stage_param.sv
// MIPS memory stage: byte/half/word data memory, branch resolve, MEM/WB register.
// Optional MEM_LAT wait states back-pressure upstream through stall.
module mem_stage_param #(
    parameter int DEPTH   = 256,
    parameter int WB_W    = 2,
    parameter int REG_W   = 5,
    parameter int MEM_LAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic [WB_W-1:0]  control_wb,
    input  logic [1:0]       branch_ctl,
    input  logic             alu_zero,
    input  logic [31:0]      address,
    input  logic [31:0]      write_data,
    input  logic [REG_W-1:0] write_register,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [1:0]       mem_size,
    input  logic             mem_unsigned,
    input  logic             flush,
    output logic             stall,
    output logic             pc_src,
    output logic             wb_valid,
    output logic [WB_W-1:0]  control_wb_out,
    output logic [31:0]      read_data_out,
    output logic [31:0]      alu_result_out,
    output logic [REG_W-1:0] write_reg_out,
    output logic             misalign
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAT = 4'(MEM_LAT);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        w_stall;

    logic [31:0] r_mem [DEPTH];

    logic [AW-1:0] w_idx;
    logic          w_is_mem;
    logic          w_mis;
    logic          w_access;
    logic          w_complete;
    logic          w_we;
    logic [3:0]    w_be;
    logic [31:0]   w_wlanes;
    logic [31:0]   w_rword;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_ext;
    logic [31:0]   w_rdata;
    logic          w_unused;

    // Address bits above the memory size are deliberately ignored (wrap).
    assign w_unused = &{1'b0, address[31:AW+2]};
    assign w_idx    = address[AW+1:2];
    assign w_is_mem = mem_read | mem_write;
    assign w_mis    = w_is_mem & (((mem_size == 2'b01) & address[0]) |
                                  (mem_size[1] & (address[1:0] != 2'b00)));
    assign w_access = ex_valid & w_is_mem & ~w_mis;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access && (MEM_LAT > 0)) begin
                    w_stall = 1'b1;
                    if (!flush) begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = LAT - 4'd1;
                    end
                end
            end
            WAIT: begin
                if (r_cnt != 4'd0) begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_state_nxt = IDLE;
                end
                if (flush) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 4'd0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign stall      = w_stall;
    assign w_complete = ex_valid & ~w_stall;
    assign w_we       = w_complete & mem_write & ~w_mis & ~flush;
    assign pc_src     = ex_valid & ~w_stall &
                        ((branch_ctl == 2'b11) |
                         ((branch_ctl == 2'b01) & alu_zero) |
                         ((branch_ctl == 2'b10) & ~alu_zero));

    always_comb begin
        w_be     = 4'b1111;
        w_wlanes = write_data;
        case (mem_size)
            2'b00: begin
                w_be     = 4'b0001 << address[1:0];
                w_wlanes = {4{write_data[7:0]}};
            end
            2'b01: begin
                w_be     = address[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{write_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
            end
        end
    end

    // Little-endian lane selection and extension of the load result.
    assign w_rword = r_mem[w_idx];
    assign w_half  = address[1] ? w_rword[31:16] : w_rword[15:0];

    always_comb begin
        w_byte = w_rword[7:0];
        case (address[1:0])
            2'b01:   w_byte = w_rword[15:8];
            2'b10:   w_byte = w_rword[23:16];
            2'b11:   w_byte = w_rword[31:24];
            default: ;
        endcase
    end

    always_comb begin
        w_ext = w_rword;
        case (mem_size)
            2'b00: w_ext = mem_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01: w_ext = mem_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: ;
        endcase
    end

    assign w_rdata = (mem_read & ~mem_write & ~w_mis) ? w_ext : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid       <= 1'b0;
            control_wb_out <= '0;
            read_data_out  <= 32'd0;
            alu_result_out <= 32'd0;
            write_reg_out  <= '0;
            misalign       <= 1'b0;
        end else if (flush || w_stall) begin
            wb_valid       <= 1'b0;
            control_wb_out <= '0;
        end else begin
            wb_valid       <= ex_valid;
            control_wb_out <= (ex_valid & ~w_mis) ? control_wb : '0;
            read_data_out  <= ex_valid ? w_rdata : 32'd0;
            alu_result_out <= address;
            write_reg_out  <= write_register;
            misalign       <= ex_valid & w_mis;
        end
    end

endmodule

// File: doc/mem_stage_param.md
# mem_stage_param

Parametrised memory stage of the five-stage MIPS pipeline, sitting between the EX/MEM register and the writeback stage. It contains the data memory and the MEM/WB pipeline register, and resolves beq/bne/jump-class branches into `pc_src`. Beyond the single-cycle word-only stage it replaces, it adds:
- byte, halfword and word loads and stores, with sign or zero extension;
- misalignment detection;
- a configurable memory latency that back-pressures the pipeline with `stall`;
- a synchronous flush of the MEM/WB register.

## Interface
- DEPTH, 256: data memory size in 32-bit words; power of two, ≥ 4.
- WB_W, 2: width of the writeback control bundle.
- REG_W, 5: destination register index width.
- MEM_LAT, 0: wait cycles per load/store (0–15).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- ex_valid  in  1  an instruction is presented this cycle.
- control_wb  in  WB_W  writeback controls, passed through.
- branch_ctl  in  2  00 none, 01 beq, 10 bne, 11 unconditional.
- alu_zero  in  1  ALU zero flag.
- address  in  32  ALU result; memory byte address.
- write_data  in  32  store data; low bits are used for byte and half stores.
- write_register  in  REG_W  destination register.
- mem_read  in  1  load.
- mem_write  in  1  store.
- mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- mem_unsigned  in  1  zero-extend loads when high.
- flush  in  1  kill the instruction in flight / bubble MEM/WB.
- stall  out  1  upstream must hold all inputs stable this cycle.
- pc_src  out  1  branch taken (combinational).
- wb_valid  out  1  MEM/WB holds a real instruction.
- control_wb_out  out  WB_W  registered writeback controls.
- read_data_out  out  32  registered, extended load data.
- alu_result_out  out  32  registered copy of `address`.
- write_reg_out  out  REG_W  registered destination.
- misalign  out  1  registered flag: the access was misaligned and suppressed.

## Operation

**Branch resolution**
- `pc_src = ex_valid & !stall & (bc==11 | bc==01&alu_zero | bc==10&!alu_zero)`, where bc = `branch_ctl`.

**Addressing and byte lanes**
- Word index = `address[log2(DEPTH)+1:2]`; upper address bits are ignored, so addresses wrap modulo 4·DEPTH.
- Memory is little-endian; the byte lane is `address[1:0]`.

**Stores**
- Byte store writes only lane `address[1:0]`.
- Half store writes lanes {1,0} or {3,2}.
- Word store writes all four lanes.
- Non-addressed bytes are unchanged.

**Loads**
- Select the addressed byte or half and sign-extend it, or zero-extend when `mem_unsigned` is high.
- Word loads are returned unmodified.

**Misalignment**
- A half access with `address[0]=1`, or a word access with `address[1:0]≠0`, is misaligned.
- A misaligned access performs no memory access and incurs no wait.
- MEM/WB then captures `misalign=1`, `control_wb_out=0` and `read_data_out=0`.

**Other cases**
- `mem_read` and `mem_write` both high: treated as a store; `read_data_out=0`.
- Non-memory instruction: passes through in one cycle with `read_data_out=0`.
- Memory contents are zero at time 0 and are not cleared by `rst`.

**FSM with states IDLE and WAIT, and a 4-bit counter `cnt`**
- IDLE, aligned access, MEM_LAT>0: `stall=1`; load `cnt<=MEM_LAT-1`; go to WAIT.
- IDLE, MEM_LAT=0 or no access: the access completes this cycle.
- WAIT, `cnt≠0`: `stall=1`; `cnt<=cnt-1`.
- WAIT, `cnt=0`: `stall=0`; the store commits / load data is captured at this edge; go to IDLE.
- While `stall=1`, MEM/WB captures a bubble (`wb_valid=0`, `control_wb_out=0`).

**Flush**
- At the edge, flush forces `wb_valid=0` and `control_wb_out=0`.
- In WAIT, flush aborts the access: the pending store is not committed, the FSM goes to IDLE, and `stall` is low from the next cycle.
- If the access is completing at the flushed edge (IDLE with MEM_LAT=0, or WAIT with `cnt=0`), the store is not committed either.

**Precedence**
- `rst` > `flush` > normal operation.

## Timing
- Reset values: `wb_valid`, `control_wb_out`, `read_data_out`, `alu_result_out`, `write_reg_out` and `misalign` are all 0; the FSM is in IDLE with `cnt=0`.
- `stall` is 0 in the cycle following the reset edge, then follows the FSM as defined in Operation.
- Latency with MEM_LAT=0: inputs sampled at edge N appear on the MEM/WB outputs after edge N.
- Latency for an aligned access with MEM_LAT=L presented in cycle k:
  - `stall` is high in cycles k…k+L-1;
  - the access completes at the end of cycle k+L;
  - the outputs are valid after that edge.
- Total occupancy is L+1 cycles.
- Back-to-back accesses: the next access is accepted in the cycle after completion; there is no extra idle cycle.
- Store-then-load to the same word in consecutive instructions returns the new data. The write commits at the earlier edge.
- `rst` asserted in WAIT: the store is not committed and `stall` is 0 in the cycle following the reset edge.

## Test plan
- MEM_LAT=0: sw 0xDEADBEEF @0x10, then lw @0x10 → `read_data_out=0xDEADBEEF`, `wb_valid=1` one cycle after each instruction, `stall` never high.
- Word 0xDEADBEEF @0x10, then lb @0x13 → 0xFFFFFFDE; lbu @0x13 → 0x000000DE; lh @0x10 → 0xFFFFBEEF; sb 0x55 @0x11 then lw → 0xDEAD55EF.
- lw @0x12 → `misalign=1`, `control_wb_out=0`, `wb_valid=1`, memory unchanged; lh @0x13 → `misalign=1`.
- MEM_LAT=3: lw presented in cycle 0 → `stall` high in cycles 0–2, low in cycle 3, data valid after edge 3; `wb_valid=0` for three edges; a second lw is accepted in cycle 4.
- MEM_LAT=3: sw, with `flush` pulsed in the first WAIT cycle → stall drops the next cycle, the word is unchanged, `wb_valid=0`.
- Branches: beq with `alu_zero=1` → `pc_src=1`; bne with `alu_zero=1` → 0; `branch_ctl=11` → 1; any branch with `ex_valid=0` → 0.
